// File: rtl/cntr_udm.sv
// Up/down modulo counter with wrap or saturate boundary handling, a one-cycle
// terminal-count pulse and a sticky boundary flag.
// Optional build macro: CNTR_PRESCALE_EN adds a step prescaler that divides
// enabled cycles by PRESCALE. With the macro undefined, every enabled,
// non-loading cycle is a step.
module cntr_udm #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned MOD_VAL     = (1 << COUNT_WIDTH) - 1,
  parameter int unsigned PRESCALE    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   up_i,
  input  logic                   mode_sat_i,
  input  logic                   load_i,
  input  logic [COUNT_WIDTH-1:0] load_val_i,
  input  logic                   clr_ovf_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   tc_o,
  output logic                   ovf_o
);

  localparam logic [COUNT_WIDTH-1:0] ModVal = COUNT_WIDTH'(MOD_VAL);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   tc_q, tc_d;
  logic                   ovf_q, ovf_d;

  logic                   step_en;   // prescaler allows a step this cycle
  logic                   step;      // a step happens on the coming edge
  logic                   at_top;
  logic                   at_bot;
  logic                   boundary;  // step that hits the end of the range
  logic [COUNT_WIDTH-1:0] load_clamped;

`ifdef CNTR_PRESCALE_EN
  localparam int unsigned PsWidth = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PsWidth-1:0] PsLast = PsWidth'(PRESCALE - 1);

  logic [PsWidth-1:0] presc_q, presc_d;

  // Prescaler phase: advances on enabled cycles, wraps at PRESCALE-1, clears on load.
  always_comb begin
    presc_d = presc_q;
    if (load_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = (presc_q == PsLast) ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler phase register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign step_en = (presc_q == PsLast);
`else
  // PRESCALE has no effect in this build; fold it into a deliberately unused net.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign step_en = 1'b1;
`endif

  assign step         = en_i & ~load_i & step_en;
  assign at_top       = (count_q == ModVal);
  assign at_bot       = (count_q == '0);
  assign boundary     = step & (up_i ? at_top : at_bot);
  assign load_clamped = (load_val_i > ModVal) ? ModVal : load_val_i;

  // Next count, terminal-count pulse and sticky flag; set beats clear on ovf.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (load_i) begin
      count_d = load_clamped;
    end else if (step) begin
      if (boundary) begin
        tc_d = 1'b1;
        if (!mode_sat_i) begin
          count_d = up_i ? '0 : ModVal;
        end
      end else begin
        count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
      end
    end

    if (boundary) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  // Counter state registers; reset overrides load, enable and flag clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_cntr_udm.sv
// Self-checking bench for cntr_udm (COUNT_WIDTH=4, MOD_VAL=9, PRESCALE=3).
// Works in both builds: define CNTR_PRESCALE_EN to exercise the prescaler.
module tb_cntr_udm;

  localparam int unsigned CW  = 4;
  localparam int unsigned MOD = 9;
  localparam int unsigned PS  = 3;
`ifdef CNTR_PRESCALE_EN
  localparam int EPS = PS;   // enabled edges per step
`else
  localparam int EPS = 1;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          up;
  logic          mode_sat;
  logic          load;
  logic [CW-1:0] load_val;
  logic          clr_ovf;
  logic [CW-1:0] count;
  logic          tc;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt = 0;
  bit m_tc  = 0;
  bit m_ovf = 0;
  int m_ps  = 0;

  cntr_udm #(
    .COUNT_WIDTH(CW),
    .MOD_VAL    (MOD),
    .PRESCALE   (PS)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .up_i      (up),
    .mode_sat_i(mode_sat),
    .load_i    (load),
    .load_val_i(load_val),
    .clr_ovf_i (clr_ovf),
    .count_o   (count),
    .tc_o      (tc),
    .ovf_o     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one clock edge, using the current input values.
  function automatic void model_edge();
    bit stepping;
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_ps = 0;
      return;
    end
    if (load) begin
      m_cnt = (int'(load_val) > MOD) ? MOD : int'(load_val);
      m_tc  = 0;
      m_ps  = 0;
      if (clr_ovf) m_ovf = 0;
      return;
    end
    stepping = 0;
    if (en) begin
      if (m_ps == EPS - 1) stepping = 1;
      m_ps = (m_ps + 1) % EPS;
    end
    m_tc = 0;
    if (stepping) begin
      if (up) begin
        if (m_cnt == MOD) begin
          m_tc = 1;
          if (!mode_sat) m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (m_cnt == 0) begin
          m_tc = 1;
          if (!mode_sat) m_cnt = MOD;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    if (m_tc) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endfunction

  // One clock edge: advance the model, then settle past the edge for sampling.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; en = 0; up = 1; mode_sat = 0; load = 0; load_val = '0; clr_ovf = 0;
  endtask

  // Hold en high for exactly one step's worth of edges (prescaler at phase 0).
  task automatic do_step();
    en = 1;
    repeat (EPS) tick();
    en = 0;
  endtask

  task automatic load_value(input int v);
    load = 1; load_val = CW'(v);
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; load = 1; load_val = 4'd6; en = 1; clr_ovf = 1;
    tick();
    tick();
    idle_inputs();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (tc !== 1'b0)    begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_wrap_up();
    int exp_cnt[3] = '{9, 0, 1};
    bit exp_tc[3]  = '{0, 1, 0};
    load_value(8);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_load got=%0d exp=8", count); end
    up = 1; mode_sat = 0;
    for (int i = 0; i < 3; i++) begin
      do_step();
      checks++;
      if (count !== CW'(exp_cnt[i]) || tc !== exp_tc[i]) begin
        errors++;
        $display("FAIL wrap_step%0d got cnt=%0d tc=%b exp cnt=%0d tc=%b",
                 i, count, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_sat_down();
    clr_ovf = 1;
    load_value(1);
    clr_ovf = 0;
    checks++;
    if (count !== 4'd1 || ovf !== 1'b0) begin
      errors++; $display("FAIL sat_load got cnt=%0d ovf=%b exp cnt=1 ovf=0", count, ovf);
    end
    up = 0; mode_sat = 1;
    for (int i = 0; i < 3; i++) begin
      do_step();
      checks++;
      if (count !== 4'd0 || tc !== (i != 0)) begin
        errors++;
        $display("FAIL sat_step%0d got cnt=%0d tc=%b exp cnt=0 tc=%b", i, count, tc, i != 0);
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", ovf); end
  endtask

  task automatic test_load_clamp();
    load = 1; load_val = 4'd14; en = 1; up = 1; mode_sat = 0;
    tick();
    load = 0;
    checks++;
    if (count !== 4'd9 || tc !== 1'b0) begin
      errors++; $display("FAIL clamp_load got cnt=%0d tc=%b exp cnt=9 tc=0", count, tc);
    end
    do_step();
    checks++;
    if (count !== 4'd0 || tc !== 1'b1) begin
      errors++; $display("FAIL clamp_wrap got cnt=%0d tc=%b exp cnt=0 tc=1", count, tc);
    end
  endtask

  task automatic test_ovf_race();
    load_value(9);
    up = 1; mode_sat = 0; clr_ovf = 1;
    do_step();
    checks++;
    if (ovf !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL race_set got ovf=%b cnt=%0d exp ovf=1 cnt=0", ovf, count);
    end
    tick();
    clr_ovf = 0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL race_clear got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid();
    load_value(0);
    up = 0; mode_sat = 1;
    do_step();
    load_value(5);
    checks++;
    if (count !== 4'd5 || ovf !== 1'b1) begin
      errors++; $display("FAIL mid_setup got cnt=%0d ovf=%b exp cnt=5 ovf=1", count, ovf);
    end
    en = 1; up = 1;
    tick();
    rst = 1; load = 1; load_val = 4'd7; en = 1;
    tick();
    idle_inputs();
    checks++;
    if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d tc=%b ovf=%b exp 0 0 0", count, tc, ovf);
    end
  endtask

  // Continuous enable from reset; a 2-cycle en=0 gap must not disturb the phase.
  task automatic test_prescale();
    int enabled = 0;
    rst = 1; tick(); rst = 0;
    up = 1; mode_sat = 0;
    for (int k = 0; k < 8; k++) begin
      en = (k == 4 || k == 5) ? 1'b0 : 1'b1;
      if (en) enabled++;
      tick();
      checks++;
      if (count !== CW'(enabled / EPS)) begin
        errors++;
        $display("FAIL prescale_edge%0d got=%0d exp=%0d", k, count, enabled / EPS);
      end
    end
    en = 0;
  endtask

  task automatic test_random();
    rst = 1; tick(); idle_inputs();
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) != 0;
      mode_sat = $urandom_range(0, 1) != 0;
      clr_ovf  = ($urandom_range(0, 5) == 0);
      load_val = CW'($urandom_range(0, 15));
      tick();
      checks++;
      if (count !== CW'(m_cnt) || tc !== m_tc || ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_cyc%0d got cnt=%0d tc=%b ovf=%b exp cnt=%0d tc=%b ovf=%b",
                 i, count, tc, ovf, m_cnt, m_tc, m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_clamp();
    test_ovf_race();
    test_reset_mid();
    test_prescale();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cntr_udm.md
CNTR_UDM -- requirements
Module: cntr_udm

Interface
REQ-001 Parameter COUNT_WIDTH, default 8, counter width in bits; SHALL be 2 or more.
REQ-002 Parameter MOD_VAL, default 2**COUNT_WIDTH-1, highest count value; the count range SHALL be 0..MOD_VAL, with 1 <= MOD_VAL <= 2**COUNT_WIDTH-1.
REQ-003 Parameter PRESCALE, default 4, step divider; SHALL be 2 or more and is used only when CNTR_PRESCALE_EN is defined.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 mode_sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  COUNT_WIDTH  value to load.
REQ-011 clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 count  output  COUNT_WIDTH  registered count value.
REQ-013 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-014 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-015 Each clock edge SHALL apply this priority: rst, then load, then step.
REQ-016 A step occurs when en=1 and load=0, subject to the prescaler (REQ-027).
REQ-017 Step when up=1 and count<MOD_VAL: count SHALL become count+1.
REQ-018 Step when up=0 and count>0: count SHALL become count-1.
REQ-019 Boundary step means up=1 with count==MOD_VAL, or up=0 with count==0.
REQ-020 Boundary step with mode_sat=0: count SHALL wrap to 0 (up) or to MOD_VAL (down).
REQ-021 Boundary step with mode_sat=1: count SHALL hold at its current value.
REQ-022 Any boundary step SHALL set tc=1 for exactly the following cycle and set ovf=1; tc SHALL be 0 in all other cycles.
REQ-023 Load: count SHALL become min(load_val, MOD_VAL) on the next edge, with no tc pulse and ovf unchanged.
REQ-024 Load and en in the same cycle: load wins, no step occurs, and the prescaler clears.
REQ-025 clr_ovf=1 SHALL clear ovf on the next edge; if a boundary step occurs in the same cycle, set wins and ovf stays 1.
REQ-026 Changing up or mode_sat SHALL take effect on the next step with no latency beyond that step; the next count value depends only on the current-cycle inputs.

Reset
REQ-028 rst=1 at a clock edge SHALL force count=0, tc=0, ovf=0 and prescaler=0, overriding load, en and clr_ovf.
REQ-029 rst asserted mid-operation (including mid-prescale or during a tc cycle) SHALL discard all state; count resumes from 0 with the prescaler at 0.
REQ-030 There SHALL be no asynchronous reset path.

Configuration
REQ-027 CNTR_PRESCALE_EN defined: an internal prescaler counts 0..PRESCALE-1 on each en=1 cycle and wraps; a step occurs only when en=1 and prescaler==PRESCALE-1. The prescaler holds when en=0 and clears on load or rst.
REQ-031 CNTR_PRESCALE_EN undefined: no prescaler logic is built, PRESCALE is ignored, and every en=1, load=0 cycle is a step.
REQ-032 Port list and all other behaviour SHALL be identical in both builds.

Verification (COUNT_WIDTH=4, MOD_VAL=9; PRESCALE=3 where enabled)
REQ-033 Wrap up: load 8, then up=1, mode_sat=0, en=1 for 3 cycles -> count 9, 0, 1; tc high exactly one cycle, in the cycle after 9->0; ovf=1.
REQ-034 Saturate down: load 1, then up=0, mode_sat=1, en=1 for 3 cycles -> count 0, 0, 0; tc pulses after each boundary step; ovf=1.
REQ-035 Load clamp and priority: load=1, load_val=14, en=1 -> count=9, no tc; next cycle load=0, up=1, mode_sat=0 -> count=0 and tc=1.
REQ-036 Overflow set/clear race: ovf=1, count=9, up=1, clr_ovf=1 on the wrap step -> ovf stays 1; a later clr_ovf with no boundary step -> ovf=0.
REQ-037 Reset mid-operation: count=5, rst=1 together with load=1, load_val=7 -> count=0, tc=0, ovf=0 on the next cycle.
REQ-038 Prescale build: en=1 continuously from reset -> count goes 0 to 1 on the 3rd enabled edge and 1 to 2 on the 6th; en=0 for 2 cycles mid-prescale -> phase held. Non-prescale build -> count increments on every enabled edge.
